// File: rtl/poly_mult_sched.sv
// Constant-time sequencer for the sparse-dense polynomial multiplier: issues exactly MAX_WEIGHT
// rotate-accumulate ops, replacing slots beyond the real weight with dummy ops.
module poly_mult_sched #(
  parameter int unsigned MAX_WEIGHT     = 75,
  parameter int unsigned WEIGHT         = 66,
  parameter int unsigned LOGW           = 16,
  parameter int unsigned LOG_WEIGHT     = 7,
  parameter int unsigned LOG_MAX_WEIGHT = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [LOG_MAX_WEIGHT-1:0] weight_i,
  input  logic [LOGW-1:0]           dummy_pos_i,
  output logic [LOG_WEIGHT-1:0]     loc_addr_o,
  input  logic [LOGW-1:0]           loc_q_i,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [LOGW-1:0]           op_shift_o,
  output logic                      op_dummy_o,
  input  logic                      dp_done_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [LOG_MAX_WEIGHT-1:0] MaxW     = LOG_MAX_WEIGHT'(MAX_WEIGHT);
  localparam logic [LOG_MAX_WEIGHT-1:0] LastSlot = LOG_MAX_WEIGHT'(MAX_WEIGHT - 1);
  localparam logic [LOG_WEIGHT-1:0]     LastAddr = LOG_WEIGHT'(WEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWaitQ,
    StIssue,
    StWaitDone,
    StFin
  } state_e;

  state_e                    state_q, state_d;
  logic [LOG_MAX_WEIGHT-1:0] slot_q, slot_d;
  logic [LOG_MAX_WEIGHT-1:0] weff_q, weff_d;
  // Tracks slot mod WEIGHT; only changes on entry to StRd, so it doubles as the held address.
  logic [LOG_WEIGHT-1:0]     addr_q, addr_d;
  logic [LOGW-1:0]           shift_q, shift_d;
  logic                      dummy_q, dummy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      slot_q  <= '0;
      weff_q  <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      dummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      weff_q  <= weff_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      dummy_q <= dummy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    weff_d  = weff_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    dummy_d = dummy_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          weff_d  = (weight_i > MaxW) ? MaxW : weight_i;
          slot_d  = '0;
          addr_d  = '0;
          state_d = StRd;
        end
      end
      StRd: state_d = StWaitQ;
      StWaitQ: begin
        // The RAM is read for every slot so real and dummy slots look identical in time.
        if (slot_q < weff_q) begin
          shift_d = loc_q_i;
          dummy_d = 1'b0;
        end else begin
          shift_d = dummy_pos_i;
          dummy_d = 1'b1;
        end
        state_d = StIssue;
      end
      StIssue: begin
        if (op_ready_i) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (dp_done_i) begin
          if (slot_q == LastSlot) begin
            state_d = StFin;
          end else begin
            slot_d  = slot_q + 1'b1;
            addr_d  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            state_d = StRd;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign loc_addr_o = addr_q;
  assign op_shift_o = shift_q;
  assign op_dummy_o = dummy_q;
  assign op_valid_o = (state_q == StIssue);
  assign done_o     = (state_q == StFin);
  assign busy_o     = (state_q != StIdle) && (state_q != StFin);

endmodule

// File: tb/tb_poly_mult_sched.sv
// Bench for poly_mult_sched: table of directed runs, hand-written reset sequence and random runs
// checked against a slot-list model of the expected op stream and completion time.
module tb_poly_mult_sched;
  localparam int MW  = 4;
  localparam int WN  = 3;
  localparam int LW  = 16;
  localparam int LWA = 2;
  localparam int LMW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic [LMW-1:0] weight_i;
  logic [LW-1:0]  dummy_pos_i;
  logic [LWA-1:0] loc_addr_o;
  logic [LW-1:0]  loc_q_i;
  logic           op_valid_o;
  logic           op_ready_i;
  logic [LW-1:0]  op_shift_o;
  logic           op_dummy_o;
  logic           dp_done_i;
  logic           busy_o;
  logic           done_o;

  poly_mult_sched #(
    .MAX_WEIGHT(MW), .WEIGHT(WN), .LOGW(LW), .LOG_WEIGHT(LWA), .LOG_MAX_WEIGHT(LMW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .weight_i(weight_i), .dummy_pos_i(dummy_pos_i),
    .loc_addr_o(loc_addr_o), .loc_q_i(loc_q_i), .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i), .op_shift_o(op_shift_o), .op_dummy_o(op_dummy_o),
    .dp_done_i(dp_done_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  logic [LW-1:0] ram [WN];
  always @(posedge clk) loc_q_i <= ram[int'(loc_addr_o) % WN];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Datapath model state
  int            op_idx = 0;
  bit            pend = 0;
  int            wait_cnt = 0;
  int            stalled = 0;
  int            stall_op = -1;
  int            stall_len = 0;
  int            done_delay = 0;
  bit            noise = 0;
  logic [LW-1:0] exp_shift [MW];
  logic [LW-1:0] rec_shift [$];
  logic          rec_dummy [$];
  logic [LWA-1:0] rec_addr [$];

  initial begin
    op_ready_i = 1'b0;
    dp_done_i  = 1'b0;
    forever begin
      @(negedge clk);
      dp_done_i = 1'b0;
      if (pend) begin
        if (wait_cnt == 0) begin
          dp_done_i = 1'b1;
          pend = 0;
        end else begin
          wait_cnt--;
        end
      end
      if (op_valid_o) begin
        if (op_idx == stall_op && stalled < stall_len) begin
          op_ready_i = 1'b0;
          stalled++;
          if (op_idx < MW) chk("stall_hold_shift", 32'(op_shift_o), 32'(exp_shift[op_idx]));
        end else begin
          op_ready_i = 1'b1;
        end
      end else begin
        op_ready_i = noise ? 1'($urandom) : 1'b0;
      end
      if (op_valid_o && op_ready_i) begin
        rec_shift.push_back(op_shift_o);
        rec_dummy.push_back(op_dummy_o);
        rec_addr.push_back(loc_addr_o);
        op_idx++;
        pend = 1;
        wait_cnt = done_delay;
      end
      if (noise && !busy_o && !pend) dp_done_i = 1'($urandom);
      if (noise && busy_o) begin
        start_i  = 1'($urandom);
        weight_i = LMW'($urandom);
      end
    end
  end

  task automatic setup(input int s_op, input int s_len, input int d_dly, input bit nz);
    @(posedge clk);
    op_idx = 0; pend = 0; stalled = 0;
    stall_op = s_op; stall_len = s_len; done_delay = d_dly; noise = nz;
    rec_shift.delete(); rec_dummy.delete(); rec_addr.delete();
  endtask

  task automatic run(input string tag, input int w, input logic [LW-1:0] dpos, input int s_op,
                     input int s_len, input int d_dly, input bit nz, input int exp_done);
    int weff;
    int t0;
    int done_at;
    bit seen;
    weff = (w > MW) ? MW : w;
    for (int s = 0; s < MW; s++) exp_shift[s] = (s < weff) ? ram[s % WN] : dpos;
    setup(s_op, s_len, d_dly, nz);
    @(negedge clk);
    weight_i = LMW'(w); dummy_pos_i = dpos; start_i = 1'b1;
    t0 = cyc; seen = 0; done_at = -1;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (cyc - t0 == 1) begin
        chk({tag, "_busy_c1"}, 32'(busy_o), 32'd1);
        start_i = 1'b0;
      end
      if (done_o) begin
        seen = 1;
        done_at = cyc - t0;
        chk({tag, "_busy_fin"}, 32'(busy_o), 32'd0);
      end
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_op_count"}, 32'(rec_shift.size()), 32'(MW));
    for (int s = 0; s < MW && s < rec_shift.size(); s++) begin
      chk({tag, "_shift"}, 32'(rec_shift[s]), 32'(exp_shift[s]));
      chk({tag, "_dummy"}, 32'(rec_dummy[s]), 32'(s >= weff));
      chk({tag, "_addr"}, 32'(rec_addr[s]), 32'(s % WN));
    end
  endtask

  typedef struct {
    string         tag;
    int            w;
    logic [LW-1:0] dpos;
    int            s_op;
    int            s_len;
    int            d_dly;
    bit            nz;
    int            exp_done;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{"t1_basic",   3, 16'd7, -1, 0, 0, 1'b0, 17};
    vt[1] = '{"t2_w0",      0, 16'd7, -1, 0, 0, 1'b0, 17};
    vt[2] = '{"t3_clamp",   9, 16'd7, -1, 0, 0, 1'b0, 17};
    vt[3] = '{"t4_stall",   3, 16'd7,  1, 3, 0, 1'b0, 20};
    vt[4] = '{"t6_noise",   3, 16'd7, -1, 0, 0, 1'b1, 17};

    ram[0] = 16'd5; ram[1] = 16'd9; ram[2] = 16'd2;
    start_i = 1'b0; weight_i = '0; dummy_pos_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(op_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_addr", 32'(loc_addr_o), 32'd0);
    chk("rst_shift", 32'(op_shift_o), 32'd0);
    chk("rst_dummy", 32'(op_dummy_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run(vt[i].tag, vt[i].w, vt[i].dpos, vt[i].s_op, vt[i].s_len, vt[i].d_dly, vt[i].nz,
          vt[i].exp_done);

    // Clamped run: slot 3 wraps to address 0 and is a real op.
    run("t3_again", 9, 16'd7, -1, 0, 0, 1'b0, 17);
    if (rec_shift.size() == MW) begin
      chk("t3_slot3_shift", 32'(rec_shift[3]), 32'd5);
      chk("t3_slot3_dummy", 32'(rec_dummy[3]), 32'd0);
      chk("t3_slot3_addr", 32'(rec_addr[3]), 32'd0);
    end

    // Reset in the WAIT_DONE phase of slot 1.
    setup(-1, 0, 5, 1'b0);
    @(negedge clk);
    weight_i = 4'd3; dummy_pos_i = 16'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 0; n < 200 && op_idx < 2; n++) @(posedge clk);
    chk("t5_reached_slot1", 32'(op_idx), 32'd2);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_valid", 32'(op_valid_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_done", 32'(done_o), 32'd0);
    chk("t5_addr", 32'(loc_addr_o), 32'd0);
    chk("t5_shift", 32'(op_shift_o), 32'd0);
    chk("t5_dummy", 32'(op_dummy_o), 32'd0);
    run("t5_restart", 3, 16'd7, -1, 0, 0, 1'b0, 17);

    for (int r = 0; r < 16; r++) begin
      int w;
      int s_op;
      int s_len;
      int d_dly;
      for (int k = 0; k < WN; k++) ram[k] = LW'($urandom);
      w     = int'($urandom_range(0, 15));
      s_op  = int'($urandom_range(0, MW));
      s_len = int'($urandom_range(0, 3));
      d_dly = int'($urandom_range(0, 2));
      run("rand", w, LW'($urandom), s_op, s_len, d_dly, 1'b1,
          MW * (4 + d_dly) + 1 + ((s_op < MW) ? s_len : 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
